// File: rtl/matrix_pwm_driver.sv
// matrix_pwm_driver: multi-chain BCM LED driver with double-buffered frame RAM and brightness-scaled OE
module matrix_pwm_driver #(
  parameter int NUM_CHANNELS   = 2,
  parameter int LEDS_PER_CHAIN = 256,
  parameter int PWM_BITS       = 16,
  parameter int LATCH_CYCLES   = 10,
  parameter int SWAP_BYTES     = 1
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_enable,
  input  logic [7:0]                           i_brightness,
  input  logic                                 i_swap_req,
  output logic                                 o_bank,
  output logic                                 o_frame_done,
  output logic                                 o_led_oe,
  output logic                                 o_led_clk,
  output logic                                 o_led_lat,
  output logic [NUM_CHANNELS-1:0]              o_led_data,
  output logic [$clog2(LEDS_PER_CHAIN):0]      o_raddr,
  input  logic [NUM_CHANNELS*PWM_BITS-1:0]     i_rdata
);
  localparam int AW = $clog2(LEDS_PER_CHAIN);
  localparam int PW = PWM_BITS > 1 ? $clog2(PWM_BITS) : 1;
  localparam int LW = LATCH_CYCLES > 1 ? $clog2(LATCH_CYCLES) : 1;
  localparam int DW = 9 + PWM_BITS;
  localparam logic [AW-1:0] FLIP = AW'(15);
  typedef enum logic [2:0] {IDLE, PREFETCH, SHIFT, WAIT_OE, LATCH, ADVANCE} state_t;
  state_t state, state_n;
  logic [AW-1:0] k, k_n;
  logic ph, ph_n, pend, pend_n;
  logic [PW-1:0] plane, plane_n;
  logic [LW-1:0] lc, lc_n;
  logic [DW-1:0] cnt, cnt_n, dval;
  logic bank_n, done_n, oe_n, lclk_n, lat_n;
  logic [NUM_CHANNELS-1:0] data_n, bits;
  logic [AW:0] raddr_n;
  genvar c;
  generate
    for (c = 0; c < NUM_CHANNELS; c++) begin : g_ch
      logic [PWM_BITS-1:0] w;
      if (SWAP_BYTES != 0) begin : g_sw
        assign w = {i_rdata[c*PWM_BITS +: 8], i_rdata[c*PWM_BITS+8 +: 8]};
      end else begin : g_ns
        assign w = i_rdata[c*PWM_BITS +: PWM_BITS];
      end
      assign bits[c] = w[plane];
    end
  endgenerate
  assign dval = (DW'(i_brightness) + DW'(1)) << plane;
  always_comb begin
    state_n = state;
    k_n = k;
    ph_n = ph;
    plane_n = plane;
    lc_n = lc;
    pend_n = pend | i_swap_req;
    bank_n = o_bank;
    done_n = 1'b0;
    lclk_n = 1'b0;
    lat_n = 1'b0;
    data_n = '0;
    raddr_n = o_raddr;
    // OE timer is free-running: counts down the display time while the next plane shifts
    oe_n = o_led_oe | (cnt == DW'(1));
    cnt_n = o_led_oe ? cnt : cnt - DW'(1);
    case (state)
      IDLE: if (i_enable) begin
        bank_n = o_bank ^ pend_n;
        pend_n = 1'b0;
        plane_n = '0;
        state_n = PREFETCH;
      end
      PREFETCH: begin
        raddr_n = {o_bank, FLIP};
        k_n = '0;
        ph_n = 1'b0;
        state_n = SHIFT;
      end
      SHIFT: if (!ph) begin
        data_n = bits;
        raddr_n = {o_bank, (k + AW'(1)) ^ FLIP};
        ph_n = 1'b1;
      end else begin
        lclk_n = 1'b1;
        data_n = o_led_data;
        ph_n = 1'b0;
        k_n = k + AW'(1);
        state_n = (k == AW'(LEDS_PER_CHAIN-1)) ? WAIT_OE : SHIFT;
      end
      WAIT_OE: if (o_led_oe) begin
        lat_n = 1'b1;
        lc_n = '0;
        state_n = LATCH;
      end
      LATCH: begin
        lat_n = 1'b1;
        lc_n = lc + LW'(1);
        if (lc == LW'(LATCH_CYCLES-1)) begin
          lat_n = 1'b0;
          oe_n = 1'b0;
          cnt_n = dval;
          state_n = ADVANCE;
        end
      end
      ADVANCE: if (plane != PW'(PWM_BITS-1)) begin
        plane_n = plane + PW'(1);
        state_n = PREFETCH;
      end else begin
        done_n = 1'b1;
        plane_n = '0;
        bank_n = o_bank ^ pend_n;
        pend_n = 1'b0;
        state_n = i_enable ? PREFETCH : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      k <= '0;
      ph <= 1'b0;
      plane <= '0;
      lc <= '0;
      cnt <= '0;
      pend <= 1'b0;
      o_bank <= 1'b0;
      o_frame_done <= 1'b0;
      o_led_oe <= 1'b1;
      o_led_clk <= 1'b0;
      o_led_lat <= 1'b0;
      o_led_data <= '0;
      o_raddr <= '0;
    end else begin
      state <= state_n;
      k <= k_n;
      ph <= ph_n;
      plane <= plane_n;
      lc <= lc_n;
      cnt <= cnt_n;
      pend <= pend_n;
      o_bank <= bank_n;
      o_frame_done <= done_n;
      o_led_oe <= oe_n;
      o_led_clk <= lclk_n;
      o_led_lat <= lat_n;
      o_led_data <= data_n;
      o_raddr <= raddr_n;
    end
  end
endmodule

// File: tb/tb_matrix_pwm_driver.sv
// tb_matrix_pwm_driver: table-driven frame checks plus swap, enable and reset sequences
module tb_matrix_pwm_driver;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, swap_req = 1'b0;
  logic [7:0] bright = 8'd0;
  logic [7:0] word = 8'hA5;
  logic [7:0] rdata = 8'h00;
  logic bank, done, oe, lclk, lat;
  logic [1:0] data;
  logic [4:0] raddr;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  always @(posedge clk) rdata <= word;
  matrix_pwm_driver #(.NUM_CHANNELS(2), .LEDS_PER_CHAIN(16), .PWM_BITS(4), .LATCH_CYCLES(3), .SWAP_BYTES(0)) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_brightness(bright), .i_swap_req(swap_req),
    .o_bank(bank), .o_frame_done(done), .o_led_oe(oe), .o_led_clk(lclk), .o_led_lat(lat),
    .o_led_data(data), .o_raddr(raddr), .i_rdata(rdata));
  int edges = 0, n0 = 0, n1 = 0, latrun = 0, oerun = 0, li = 0, oi = 0, ri = 0, dones = 0, viol = 0;
  int lat_len[256], e_arr[256], n0_arr[256], n1_arr[256], oe_arr[256], ra_log[256];
  logic pclk = 1'b0, plat = 1'b0, poe = 1'b1;
  logic [4:0] pra = 5'd0;
  always @(negedge clk) begin
    if (lclk && !pclk) begin
      edges++;
      n0 += int'(data[0]);
      n1 += int'(data[1]);
    end
    if (lat) latrun++;
    if (!lat && plat && li < 256) begin
      lat_len[li] = latrun; e_arr[li] = edges; n0_arr[li] = n0; n1_arr[li] = n1;
      li++; edges = 0; n0 = 0; n1 = 0; latrun = 0;
    end
    if (lat && !oe) viol++;
    if (!oe) oerun++;
    if (oe && !poe && oi < 256) begin
      oe_arr[oi] = oerun; oi++; oerun = 0;
    end
    if (done) dones++;
    if (raddr != pra && ri < 256) begin
      ra_log[ri] = int'(raddr); ri++;
    end
    pclk = lclk; plat = lat; poe = oe; pra = raddr;
  end
  typedef struct packed {
    logic [7:0] b;
    logic [3:0] w0, w1;
    logic [3:0][11:0] oe;
    logic [3:0][4:0] n0, n1;
  } vec_t;
  vec_t vt[4];
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask
  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic wait_li(input int t);
    for (int i = 0; i < 20000 && li < t; i++) step();
    chk("wait_latch", int'(li >= t), 1);
  endtask
  task automatic wait_oi(input int t);
    for (int i = 0; i < 20000 && oi < t; i++) step();
    chk("wait_oe", int'(oi >= t), 1);
  endtask
  task automatic pulse_enable();
    enable = 1'b1;
    step();
    enable = 1'b0;
  endtask
  int bl, bo, d0, rb;
  initial begin
    vt[0].b = 8'd0;   vt[0].w0 = 4'h5; vt[0].w1 = 4'hA; vt[0].oe = {12'd8, 12'd4, 12'd2, 12'd1};
    vt[0].n0 = {5'd0, 5'd16, 5'd0, 5'd16}; vt[0].n1 = {5'd16, 5'd0, 5'd16, 5'd0};
    vt[1].b = 8'd3;   vt[1].w0 = 4'h5; vt[1].w1 = 4'hA; vt[1].oe = {12'd32, 12'd16, 12'd8, 12'd4};
    vt[1].n0 = {5'd0, 5'd16, 5'd0, 5'd16}; vt[1].n1 = {5'd16, 5'd0, 5'd16, 5'd0};
    vt[2].b = 8'd255; vt[2].w0 = 4'hF; vt[2].w1 = 4'h0; vt[2].oe = {12'd2048, 12'd1024, 12'd512, 12'd256};
    vt[2].n0 = {5'd16, 5'd16, 5'd16, 5'd16}; vt[2].n1 = {5'd0, 5'd0, 5'd0, 5'd0};
    vt[3].b = 8'd1;   vt[3].w0 = 4'h3; vt[3].w1 = 4'hC; vt[3].oe = {12'd16, 12'd8, 12'd4, 12'd2};
    vt[3].n0 = {5'd0, 5'd0, 5'd16, 5'd16}; vt[3].n1 = {5'd16, 5'd16, 5'd0, 5'd0};
    step(3);
    rst = 1'b0;
    step(3);
    chk("rst_oe", int'(oe), 1);
    chk("rst_clk", int'(lclk), 0);
    chk("rst_lat", int'(lat), 0);
    chk("rst_data", int'(data), 0);
    chk("rst_bank", int'(bank), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_raddr", int'(raddr), 0);
    rb = ri;
    for (int v = 0; v < 4; v++) begin
      word = {vt[v].w1, vt[v].w0};
      bright = vt[v].b;
      bl = li; bo = oi;
      step();
      pulse_enable();
      wait_oi(bo + 4);
      for (int p = 0; p < 4; p++) begin
        chk($sformatf("v%0d_p%0d_oe_len", v, p), oe_arr[bo+p], int'(vt[v].oe[p]));
        chk($sformatf("v%0d_p%0d_lat_len", v, p), lat_len[bl+p], 3);
        chk($sformatf("v%0d_p%0d_clk_edges", v, p), e_arr[bl+p], 16);
        chk($sformatf("v%0d_p%0d_ones0", v, p), n0_arr[bl+p], int'(vt[v].n0[p]));
        chk($sformatf("v%0d_p%0d_ones1", v, p), n1_arr[bl+p], int'(vt[v].n1[p]));
      end
      if (v == 0)
        for (int i = 0; i < 16; i++) chk($sformatf("raddr_seq%0d", i), ra_log[rb+i], 15 - i);
    end
    chk("lat_during_oe_low", viol, 0);
    word = 8'hA5; bright = 8'd0;
    bl = li; bo = oi; d0 = dones;
    pulse_enable();
    wait_li(bl + 1);
    swap_req = 1'b1; step(); swap_req = 1'b0; step(4);
    swap_req = 1'b1; step(); swap_req = 1'b0;
    wait_oi(bo + 4);
    chk("swap_done_pulses", dones - d0, 1);
    chk("swap_bank", int'(bank), 1);
    bo = oi;
    pulse_enable();
    step(8);
    chk("swap_raddr_msb", int'(raddr[4]), 1);
    wait_oi(bo + 4);
    chk("swap_bank_held", int'(bank), 1);
    bl = li; bo = oi; d0 = dones;
    enable = 1'b1;
    step();
    wait_li(bl + 2);
    enable = 1'b0;
    wait_oi(bo + 4);
    chk("en_done_pulses", dones - d0, 1);
    chk("en_last_oe_len", oe_arr[bo+3], 8);
    step(60);
    chk("en_planes_latched", li - bl, 4);
    chk("en_oe_runs", oi - bo, 4);
    chk("en_idle_oe", int'(oe), 1);
    chk("en_idle_clk", int'(lclk), 0);
    bright = 8'd255; bl = li;
    pulse_enable();
    wait_li(bl + 1);
    step(5);
    chk("pre_rst_oe_low", int'(oe), 0);
    rst = 1'b1;
    step();
    chk("midrst_oe", int'(oe), 1);
    chk("midrst_clk", int'(lclk), 0);
    chk("midrst_lat", int'(lat), 0);
    chk("midrst_data", int'(data), 0);
    chk("midrst_bank", int'(bank), 0);
    chk("midrst_raddr", int'(raddr), 0);
    rst = 1'b0;
    step(40);
    chk("post_rst_oe", int'(oe), 1);
    chk("post_rst_clk", int'(lclk), 0);
    chk("post_rst_lat", int'(lat), 0);
    chk("post_rst_raddr", int'(raddr), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
